// File: rtl/rd_arb_pkg.sv
// Shared types and default widths for the AXI read-request arbiter.
//   req_t        : one requester's burst request (start address, beat count)
//   arb_state_e  : AR-issue FSM states
package rd_arb_pkg;

  localparam int AXIADDR_WIDTH = 32;
  localparam int AXIDATA_WIDTH = 128;
  localparam int BURSTBIT      = 8;

  typedef struct packed {
    logic [AXIADDR_WIDTH-1:0] addr;
    logic [BURSTBIT-1:0]      burst;
  } req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ADDR  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rd_req_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Picks the first set bit of valid at or above ptr, wrapping from N-1 to 0.
//   valid : request vector
//   ptr   : search start index (must be < N)
//   idx   : winning index (0 when nothing is found)
//   found : at least one valid bit was set
module rr_pick
  import rd_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int              cand;
    logic [IW-1:0]   cand_idx;
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (!found && valid[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/rd_req_arbiter.sv
// Shares one AXI4 read port among REQ_NUM burst requesters (0 = map_ctrl,
// 1.. = pixel-cache line fillers). Round-robin AR arbitration with a cap on
// outstanding bursts; R beats are steered back combinationally by rid.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   req_valid/req_addr/req_burst   per-requester burst requests (held until ready)
//   req_ready                      one-cycle accept pulse to the winner
//   m_ar*                          AXI AR channel (master side)
//   m_r*                           AXI R channel (master side)
//   rsp_valid/rsp_data/rsp_last    per-requester beat delivery (shared data bus)
//   rsp_ready                      per-requester beat acceptance
//
// State  | meaning
// IDLE   | waiting for a request while below the outstanding cap
// GRANT  | one cycle: pick winner, pulse req_ready, latch AR fields
// ADDR   | m_arvalid high until m_arready
module rd_req_arbiter #(
  parameter int REQ_NUM         = 3,
  parameter int AXIADDR_WIDTH   = rd_arb_pkg::AXIADDR_WIDTH,
  parameter int AXIDATA_WIDTH   = rd_arb_pkg::AXIDATA_WIDTH,
  parameter int BURSTBIT        = rd_arb_pkg::BURSTBIT,
  parameter int OUTSTANDING_NUM = 4,
  localparam int ID_WIDTH       = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [REQ_NUM-1:0]                    req_valid,
  input  logic [REQ_NUM-1:0][AXIADDR_WIDTH-1:0] req_addr,
  input  logic [REQ_NUM-1:0][BURSTBIT-1:0]      req_burst,
  output logic [REQ_NUM-1:0]                    req_ready,
  output logic [AXIADDR_WIDTH-1:0]              m_araddr,
  output logic [BURSTBIT-1:0]                   m_arlen,
  output logic [ID_WIDTH-1:0]                   m_arid,
  output logic                                  m_arvalid,
  input  logic                                  m_arready,
  input  logic                                  m_rvalid,
  input  logic [AXIDATA_WIDTH-1:0]              m_rdata,
  input  logic                                  m_rlast,
  input  logic [ID_WIDTH-1:0]                   m_rid,
  output logic                                  m_rready,
  output logic [REQ_NUM-1:0]                    rsp_valid,
  output logic [AXIDATA_WIDTH-1:0]              rsp_data,
  output logic                                  rsp_last,
  input  logic [REQ_NUM-1:0]                    rsp_ready
);

  import rd_arb_pkg::*;

  localparam int CNT_W = $clog2(OUTSTANDING_NUM + 1);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q;
  logic [ID_WIDTH-1:0] win_idx;
  logic                win_found;
  logic [CNT_W-1:0]    cnt_q;
  req_t                win_req;
  logic                can_issue;
  logic                ar_hs;
  logic                r_done;

  rr_pick #(
    .N  (REQ_NUM),
    .IW (ID_WIDTH)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .idx   (win_idx),
    .found (win_found)
  );

  assign win_req.addr  = req_addr[win_idx];
  assign win_req.burst = req_burst[win_idx];

  assign can_issue = (cnt_q < CNT_W'(OUTSTANDING_NUM));
  assign m_arvalid = (state_q == ADDR);
  assign ar_hs     = m_arvalid && m_arready;
  // A stray rlast with nothing outstanding must not wrap the counter.
  assign r_done    = m_rvalid && m_rready && m_rlast && (cnt_q != '0);

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid && can_issue) state_d = GRANT;
      end
      GRANT: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          state_d            = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (m_arready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      m_araddr <= '0;
      m_arlen  <= '0;
      m_arid   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == GRANT && win_found) begin
        m_araddr <= win_req.addr;
        m_arlen  <= win_req.burst - 1'b1;
        m_arid   <= win_idx;
        ptr_q    <= (win_idx == ID_WIDTH'(REQ_NUM - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      case ({ar_hs, r_done})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Unknown rid: accept and drop the beat so the interconnect never stalls.
  always_comb begin
    rsp_valid = '0;
    m_rready  = 1'b1;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (m_rid == ID_WIDTH'(i)) begin
        rsp_valid[i] = m_rvalid;
        m_rready     = rsp_ready[i];
      end
    end
  end

  assign rsp_data = m_rdata;
  assign rsp_last = m_rlast;

endmodule

// File: tb/tb_rd_req_arbiter.sv
module tb_rd_req_arbiter;

  localparam int REQ_NUM = 3;
  localparam int AW      = 32;
  localparam int DW      = 128;
  localparam int BB      = 8;
  localparam int IDW     = 2;

  logic                       clk = 1'b0;
  logic                       rstn;
  logic [REQ_NUM-1:0]         req_valid;
  logic [REQ_NUM-1:0][AW-1:0] req_addr;
  logic [REQ_NUM-1:0][BB-1:0] req_burst;
  logic [REQ_NUM-1:0]         req_ready;
  logic [AW-1:0]              m_araddr;
  logic [BB-1:0]              m_arlen;
  logic [IDW-1:0]             m_arid;
  logic                       m_arvalid;
  logic                       m_arready;
  logic                       m_rvalid;
  logic [DW-1:0]              m_rdata;
  logic                       m_rlast;
  logic [IDW-1:0]             m_rid;
  logic                       m_rready;
  logic [REQ_NUM-1:0]         rsp_valid;
  logic [DW-1:0]              rsp_data;
  logic                       rsp_last;
  logic [REQ_NUM-1:0]         rsp_ready;

  rd_req_arbiter dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_burst (req_burst),
    .req_ready (req_ready),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arid    (m_arid),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .m_rlast   (m_rlast),
    .m_rid     (m_rid),
    .m_rready  (m_rready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ar_hs_cnt = 0;

  always @(posedge clk) if (m_arvalid && m_arready) ar_hs_cnt <= ar_hs_cnt + 1;

  typedef struct packed {
    logic           rvalid;
    logic [IDW-1:0] rid;
    logic           rlast;
    logic [2:0]     rdy;
    logic [DW-1:0]  data;
    logic [2:0]     exp_rv;
    logic           exp_rr;
  } rvec_t;

  rvec_t vecs [7];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rlast   = 1'b0;
    m_rid     = '0;
    rsp_ready = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic wait_grant(output logic [2:0] vec);
    bit done;
    vec  = '0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      #1;
      if (req_ready != '0) begin
        vec  = req_ready;
        done = 1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g;
    int         ar0;

    vecs[0] = '{1'b0, 2'd0, 1'b0, 3'b111, 128'h0, 3'b000, 1'b1};
    vecs[1] = '{1'b1, 2'd0, 1'b0, 3'b001, 128'hA5A5_0001, 3'b001, 1'b1};
    vecs[2] = '{1'b1, 2'd1, 1'b0, 3'b001, 128'hA5A5_0002, 3'b010, 1'b0};
    vecs[3] = '{1'b1, 2'd2, 1'b0, 3'b011, 128'hA5A5_0003, 3'b100, 1'b0};
    vecs[4] = '{1'b1, 2'd2, 1'b0, 3'b100, 128'hA5A5_0004, 3'b100, 1'b1};
    vecs[5] = '{1'b1, 2'd3, 1'b0, 3'b000, 128'hA5A5_0005, 3'b000, 1'b1};
    vecs[6] = '{1'b1, 2'd1, 1'b1, 3'b010, 128'hDEAD_BEEF, 3'b010, 1'b1};

    req_addr  = '0;
    req_burst = '0;
    idle_inputs();
    rstn = 1'b0;
    #12;
    check("reset req_ready", 160'(req_ready), 160'(3'b000));
    check("reset arvalid",   160'(m_arvalid), 160'(1'b0));
    check("reset araddr",    160'(m_araddr),  160'(32'h0));
    check("reset arlen",     160'(m_arlen),   160'(8'h0));
    check("reset arid",      160'(m_arid),    160'(2'd0));
    do_reset();

    // R routing table (count is 0, so rlast beats here are stray and ignored)
    for (int i = 0; i < 7; i++) begin
      m_rvalid  = vecs[i].rvalid;
      m_rid     = vecs[i].rid;
      m_rlast   = vecs[i].rlast;
      rsp_ready = vecs[i].rdy;
      m_rdata   = vecs[i].data;
      #1;
      check($sformatf("vec%0d rsp_valid", i), 160'(rsp_valid), 160'(vecs[i].exp_rv));
      check($sformatf("vec%0d m_rready", i),  160'(m_rready),  160'(vecs[i].exp_rr));
      check($sformatf("vec%0d rsp_data", i),  160'(rsp_data),  160'(vecs[i].data));
      check($sformatf("vec%0d rsp_last", i),  160'(rsp_last),  160'(vecs[i].rlast));
      step();
    end
    idle_inputs();

    // Single request latency
    m_arready    = 1'b1;
    req_valid    = 3'b001;
    req_addr[0]  = 32'h0001_0000;
    req_burst[0] = 8'd16;
    step();
    #1;
    check("lat req_ready N+1", 160'(req_ready), 160'(3'b001));
    check("lat arvalid N+1",   160'(m_arvalid), 160'(1'b0));
    step();
    req_valid = 3'b000;
    #1;
    check("lat arvalid N+2",   160'(m_arvalid), 160'(1'b1));
    check("lat araddr",        160'(m_araddr),  160'(32'h0001_0000));
    check("lat arlen",         160'(m_arlen),   160'(8'd15));
    check("lat arid",          160'(m_arid),    160'(2'd0));
    check("lat req_ready N+2", 160'(req_ready), 160'(3'b000));
    step();
    #1;
    check("lat arvalid N+3",   160'(m_arvalid), 160'(1'b0));

    // Round robin with all requesters held valid; R drains continuously
    do_reset();
    req_addr  = {32'h3000, 32'h2000, 32'h1000};
    req_burst = {8'd4, 8'd2, 8'd1};
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b1;
    m_rid     = 2'd0;
    rsp_ready = 3'b111;
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_grant(g);
      check($sformatf("rr grant %0d", k), 160'(g), 160'(3'b001 << (k % 3)));
      step();
      #1;
      check($sformatf("rr arid %0d", k), 160'({m_arvalid, m_arid}), 160'({1'b1, 2'(k % 3)}));
    end
    idle_inputs();

    // AR stall: fields stable, no further grant while in ADDR
    do_reset();
    req_addr[1]  = 32'h2000;
    req_burst[1] = 8'd4;
    req_addr[2]  = 32'h3000;
    req_burst[2] = 8'd8;
    req_valid    = 3'b110;
    wait_grant(g);
    check("stall grant", 160'(g), 160'(3'b010));
    step();
    req_valid = 3'b100;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("stall ar fields c%0d", c),
            160'({m_arvalid, m_arid, m_arlen, m_araddr}), 160'({1'b1, 2'd1, 8'd3, 32'h2000}));
      check($sformatf("stall req_ready c%0d", c), 160'(req_ready), 160'(3'b000));
      step();
    end
    m_arready = 1'b1;
    wait_grant(g);
    check("stall next grant", 160'(g), 160'(3'b100));
    step();
    req_valid = 3'b000;
    step();

    // Outstanding cap: 4 ARs without R, 5th after one rlast
    do_reset();
    m_arready = 1'b1;
    req_valid = 3'b111;
    ar0 = ar_hs_cnt;
    for (int c = 0; c < 40; c++) step();
    check("cap ar count", 160'(ar_hs_cnt - ar0), 160'(4));
    check("cap arvalid idle", 160'(m_arvalid), 160'(1'b0));
    m_rvalid  = 1'b1;
    m_rid     = 2'd0;
    m_rlast   = 1'b1;
    rsp_ready = 3'b001;
    step();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    for (int c = 0; c < 12; c++) step();
    check("cap ar after rlast", 160'(ar_hs_cnt - ar0), 160'(5));

    // R backpressure on rid 2, then release with rlast
    m_rvalid  = 1'b1;
    m_rid     = 2'd2;
    m_rlast   = 1'b0;
    m_rdata   = 128'h1234_5678;
    rsp_ready = 3'b011;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp rsp_valid c%0d", c), 160'(rsp_valid), 160'(3'b100));
      check($sformatf("bp m_rready c%0d", c),  160'(m_rready),  160'(1'b0));
      step();
    end
    rsp_ready = 3'b100;
    m_rlast   = 1'b1;
    #1;
    check("bp m_rready released", 160'(m_rready), 160'(1'b1));
    step();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    for (int c = 0; c < 12; c++) step();
    check("bp ar after rlast", 160'(ar_hs_cnt - ar0), 160'(6));

    // Reset while in ADDR: immediate clear, pointer back to 0, count cleared
    do_reset();
    m_arready = 1'b1;
    req_valid = 3'b010;
    wait_grant(g);
    check("rst pre grant", 160'(g), 160'(3'b010));
    step();
    req_valid = 3'b000;
    step();
    m_arready = 1'b0;
    req_valid = 3'b010;
    wait_grant(g);
    check("rst second grant", 160'(g), 160'(3'b010));
    step();
    req_valid = 3'b000;
    #1;
    check("rst arvalid before", 160'(m_arvalid), 160'(1'b1));
    #1;
    rstn = 1'b0;
    #1;
    check("rst arvalid async", 160'(m_arvalid), 160'(1'b0));
    check("rst ar fields async", 160'({m_arid, m_arlen, m_araddr}), 160'(0));
    step();
    rstn      = 1'b1;
    m_arready = 1'b1;
    req_valid = 3'b111;
    ar0 = ar_hs_cnt;
    wait_grant(g);
    check("rst first grant", 160'(g), 160'(3'b001));
    for (int c = 0; c < 40; c++) step();
    check("rst count cleared", 160'(ar_hs_cnt - ar0), 160'(4));
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
